stage_1_fetch: RTL and testbench
================================

# stage_1_fetch

Pipeline stage 1 (instruction fetch) for the five-stage RV32I core. It owns the fetch program counter and issues one instruction-memory request at a time over a ready handshake. It delivers `instruction`/`pc` pairs to stage 2 (decode), holds them while decode requests a stall, and squashes to a NOP bubble when a taken jump or branch redirects the PC.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default `32'h0000_0013` (`addi x0,x0,0`): bubble instruction.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  decode stall request; outputs must hold.
- `redirect_enable_in`  in  1  taken jump/branch from execute.
- `redirect_address_in`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `imem_req_out`  out  1  memory request; high only in state REQ.
- `imem_addr_out`  out  32  equals `fetch_pc`; stable while `imem_req_out && !imem_ready_in`.
- `imem_ready_in`  in  1  `imem_rdata_in` is valid for `imem_addr_out` this cycle.
- `imem_rdata_in`  in  32  instruction word.
- `instruction_out`  out  32  registered instruction to decode.
- `pc_out`  out  32  registered address of `instruction_out`.
- `valid_out`  out  1  high means real instruction; low means bubble.

## Operation
- Internal state: `fetch_pc` (32), FSM {REQ, HOLD}, `hold_instr` (32), `hold_pc` (32).
- Reset values (asynchronous):
  - state REQ, `fetch_pc`=`RESET_PC`.
  - `instruction_out`=`NOP_INSTR`, `pc_out`=`RESET_PC`, `valid_out`=0.
  - hold registers = 0.
  - `imem_req_out` goes high immediately after `rst_n` deasserts.
- REQ, priority order each cycle:
  1. `redirect_enable_in`: `fetch_pc`<=target&~3; outputs<=NOP/`valid`=0, `pc_out` unchanged; any `imem_ready_in` this cycle is discarded. Redirect beats stall.
  2. `imem_ready_in && !stall_in`: `instruction_out`<=rdata, `pc_out`<=`fetch_pc`, `valid_out`<=1, `fetch_pc`<=`fetch_pc`+4.
  3. `imem_ready_in && stall_in`: `hold_instr`<=rdata, `hold_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4, go HOLD; outputs unchanged.
  4. `!imem_ready_in && !stall_in`: outputs<=NOP, `valid_out`<=0; `fetch_pc` unchanged (request persists).
  5. `!imem_ready_in && stall_in`: everything unchanged.
- HOLD: `imem_req_out`=0.
  - `redirect_enable_in`: drop buffer, `fetch_pc`<=target&~3, outputs<=NOP/`valid`=0, go REQ.
  - else `!stall_in`: outputs<=`hold_instr`/`hold_pc`/`valid`=1, go REQ.
  - else stay in HOLD.
- Arithmetic: `fetch_pc`+4 is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- At most one outstanding request. No instruction is lost or duplicated across stalls. No instruction fetched before a redirect reaches decode after it.

## Timing
- Latency: a word accepted (ready) in cycle N appears on outputs in cycle N+1.
- With `imem_ready_in` tied high and no stall or redirect: one instruction per cycle with consecutive PCs.
- Redirect in cycle N: outputs are a bubble in N+1; the target is requested in N+1 and appears in N+2 at the earliest.
- Stall: outputs are frozen in every cycle `stall_in` is high, unless a redirect occurs.
- Reset asserted mid-request: `imem_req_out` drops combinationally and the in-flight response is ignored. The memory must tolerate an abandoned request.

## Test plan
- Reset, ready tied high: outputs `NOP_INSTR`/0/0 during reset; then `pc_out` = 0, 4, 8, … on consecutive cycles with `valid_out`=1 and instruction matching memory.
- Ready low for 3 cycles at address 0x8: three bubbles (`valid_out`=0, NOP); `imem_addr_out` stays 0x8; then the word at 0x8 is delivered with `pc_out`=0x8.
- Stall 2 cycles while ready high at 0x10: outputs hold the 0xC instruction; `imem_req_out` is low in HOLD; 0x10 is delivered in the cycle after stall falls; no PC skipped or repeated.
- Redirect to 0x103 while ready high at 0x20: the 0x20 word is discarded; bubble next cycle; `imem_addr_out`=0x100; next valid `pc_out`=0x100.
- Redirect and stall in the same cycle while in HOLD: buffer dropped, bubble output, fetch restarts at target.
- `RESET_PC`=0xFFFF_FFFC: second fetch address is 0x0; async `rst_n` pulse mid-wait returns all outputs to reset values immediately.

Source files
------------

// File: rtl/stage_1_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage_1_fetch
// Description : RV32I instruction-fetch stage; one outstanding imem request,
//               stall buffering and redirect squash toward decode.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_1_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        redirect_enable_in,
    input  logic [31:0] redirect_address_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [31:0] w_target;
    assign w_target = {redirect_address_in[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;

        case (state_q)
            S_REQ: begin
                if (redirect_enable_in) begin
                    // Any word returned this cycle belongs to the wrong path.
                    fetch_pc_d = w_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                end else if (imem_ready_in && !stall_in) begin
                    instr_d    = imem_rdata_in;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (imem_ready_in) begin
                    hold_instr_d = imem_rdata_in;
                    hold_pc_d    = fetch_pc_q;
                    fetch_pc_d   = fetch_pc_q + 32'd4;
                    state_d      = S_HOLD;
                end else if (!stall_in) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect_enable_in) begin
                    fetch_pc_d = w_target;
                    instr_d    = NOP_INSTR;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                end else if (!stall_in) begin
                    instr_d = hold_instr_q;
                    pc_d    = hold_pc_q;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            instr_q      <= NOP_INSTR;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
        end
    end

    // Gating with rst_n abandons an in-flight request the moment reset asserts.
    assign imem_req_out    = rst_n && (state_q == S_REQ);
    assign imem_addr_out   = fetch_pc_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign valid_out       = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_1_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_1_fetch
// Description : Directed self-checking bench for stage_1_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_1_fetch;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n;
    logic        stall, redir, ready;
    logic [31:0] redir_addr;

    logic        req0, req1, valid0, valid1;
    logic [31:0] addr0, addr1, rdata0, rdata1, instr0, instr1, pc0, pc1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign rdata0 = mem(addr0);
    assign rdata1 = mem(addr1);

    stage_1_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(C_NOP)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .stall_in(stall),
        .redirect_enable_in(redir), .redirect_address_in(redir_addr),
        .imem_req_out(req0), .imem_addr_out(addr0),
        .imem_ready_in(ready), .imem_rdata_in(rdata0),
        .instruction_out(instr0), .pc_out(pc0), .valid_out(valid0)
    );

    stage_1_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(C_NOP)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .stall_in(stall),
        .redirect_enable_in(redir), .redirect_address_in(redir_addr),
        .imem_req_out(req1), .imem_addr_out(addr1),
        .imem_ready_in(ready), .imem_rdata_in(rdata1),
        .instruction_out(instr1), .pc_out(pc1), .valid_out(valid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out0(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                        input logic ev);
        chk({tag, ".instr"}, instr0, ei);
        chk({tag, ".pc"}, pc0, ep);
        chk({tag, ".valid"}, {31'd0, valid0}, {31'd0, ev});
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        stall = 1'b0; redir = 1'b0; ready = 1'b1; redir_addr = 32'd0;

        tick(); tick();
        out0("reset", C_NOP, 32'h0, 1'b0);
        chk("reset.req", {31'd0, req0}, 32'd0);

        rst0_n = 1'b1;
        #1;
        chk("post_reset.req", {31'd0, req0}, 32'd1);
        chk("post_reset.addr", addr0, 32'h0);

        // Streaming with ready tied high
        tick(); out0("s0", mem(32'h0), 32'h0, 1'b1);
        chk("s0.addr", addr0, 32'h4);
        tick(); out0("s4", mem(32'h4), 32'h4, 1'b1);
        chk("s4.addr", addr0, 32'h8);

        // Memory wait at 0x8 for three cycles
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            out0("wait", C_NOP, 32'h4, 1'b0);
            chk("wait.addr", addr0, 32'h8);
            chk("wait.req", {31'd0, req0}, 32'd1);
        end
        ready = 1'b1;
        tick(); out0("s8", mem(32'h8), 32'h8, 1'b1);
        tick(); out0("sC", mem(32'hC), 32'hC, 1'b1);

        // Stall two cycles while 0x10 is returned
        stall = 1'b1;
        tick(); out0("stall1", mem(32'hC), 32'hC, 1'b1);
        chk("stall1.req", {31'd0, req0}, 32'd0);
        tick(); out0("stall2", mem(32'hC), 32'hC, 1'b1);
        chk("stall2.req", {31'd0, req0}, 32'd0);
        stall = 1'b0;
        tick(); out0("s10", mem(32'h10), 32'h10, 1'b1);
        chk("s10.req", {31'd0, req0}, 32'd1);
        chk("s10.addr", addr0, 32'h14);
        tick(); out0("s14", mem(32'h14), 32'h14, 1'b1);
        tick(); out0("s18", mem(32'h18), 32'h18, 1'b1);
        tick(); out0("s1C", mem(32'h1C), 32'h1C, 1'b1);
        chk("s1C.addr", addr0, 32'h20);

        // Redirect to 0x103 while 0x20 is ready: 0x20 discarded
        redir = 1'b1; redir_addr = 32'h0000_0103;
        tick(); out0("redir", C_NOP, 32'h1C, 1'b0);
        chk("redir.addr", addr0, 32'h100);
        redir = 1'b0;
        tick(); out0("s100", mem(32'h100), 32'h100, 1'b1);
        tick(); out0("s104", mem(32'h104), 32'h104, 1'b1);

        // Enter HOLD with 0x108 buffered, then redirect+stall together
        stall = 1'b1;
        tick(); out0("hold", mem(32'h104), 32'h104, 1'b1);
        chk("hold.req", {31'd0, req0}, 32'd0);
        redir = 1'b1; redir_addr = 32'h0000_0200;
        tick(); out0("hredir", C_NOP, 32'h104, 1'b0);
        chk("hredir.addr", addr0, 32'h200);
        chk("hredir.req", {31'd0, req0}, 32'd1);
        redir = 1'b0; stall = 1'b0;
        tick(); out0("s200", mem(32'h200), 32'h200, 1'b1);

        // Stall while memory not ready: everything frozen
        ready = 1'b0; stall = 1'b1;
        tick(); out0("frz", mem(32'h200), 32'h200, 1'b1);
        chk("frz.addr", addr0, 32'h204);
        ready = 1'b1; stall = 1'b0;
        tick(); out0("s204", mem(32'h204), 32'h204, 1'b1);

        // Second instance: RESET_PC at the top of the address space
        rst1_n = 1'b1;
        #1;
        chk("top.addr0", addr1, 32'hFFFF_FFFC);
        tick();
        chk("top.pc", pc1, 32'hFFFF_FFFC);
        chk("top.instr", instr1, mem(32'hFFFF_FFFC));
        chk("top.wrap", addr1, 32'h0);
        ready = 1'b0;
        tick();
        chk("top.wait_valid", {31'd0, valid1}, 32'd0);
        #3;
        rst1_n = 1'b0;
        #1;
        chk("arst.req", {31'd0, req1}, 32'd0);
        chk("arst.instr", instr1, C_NOP);
        chk("arst.pc", pc1, 32'hFFFF_FFFC);
        chk("arst.valid", {31'd0, valid1}, 32'd0);
        chk("arst.addr", addr1, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
